// File: rtl/rc4_ctrl.sv
// rc4_ctrl: sequencer and sole master of the 256x8 RC4 S-box RAM.
// Holds the key and re-initialises S to the identity permutation. It then
// runs the key schedule (KSA) and the keystream generator (PRGA), and
// streams keystream bytes out over a valid/ready handshake.
// Optional feature: define RC4_DROP_EN to discard the first DROP_N
// keystream bytes after the key schedule.
module rc4_ctrl #(
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 256,
  localparam int KLW    = $clog2(KEY_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_we,
  input  logic [KLW-1:0] key_addr,
  input  logic [7:0]     key_data,
  input  logic [KLW-1:0] key_len,
  input  logic           start,
  input  logic           clear,
  output logic           busy,
  output logic           gen_active,
  output logic [7:0]     ks_data,
  output logic           ks_valid,
  input  logic           ks_ready,
  output logic [7:0]     ram_raddr_1,
  input  logic [7:0]     ram_rdata_1,
  output logic [7:0]     ram_waddr_2,
  output logic [7:0]     ram_wdata_2,
  output logic           ram_wen_2,
  output logic [7:0]     ram_addr_3,
  output logic [7:0]     ram_wdata_3,
  output logic           ram_wen_3,
  input  logic [7:0]     ram_rdata_3
);

  // Key array index width; klen never exceeds KEY_MAX so k stays in range.
  localparam int KAW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam logic [KLW-1:0] KMAX_L = KLW'(KEY_MAX);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_KSA_RD   = 4'd2,
    ST_KSA_SW1  = 4'd3,
    ST_KSA_SW2  = 4'd4,
    ST_GEN_RD   = 4'd5,
    ST_GEN_SW1  = 4'd6,
    ST_GEN_SW2  = 4'd7,
    ST_GEN_HOLD = 4'd8
  } state_t;

  state_t         state_r;
  logic [7:0]     i_r;
  logic [7:0]     j_r;
  logic [KLW-1:0] k_r;
  logic [7:0]     si_r;
  logic [7:0]     sj_r;
  logic [7:0]     cnt_r;
  logic [KLW-1:0] klen_r;
  logic [7:0]     key_r [KEY_MAX];
  logic           busy_r;
  logic           gen_active_r;
  logic [7:0]     ks_data_r;
  logic           ks_valid_r;

  logic [7:0]     raddr_1_s;
  logic [7:0]     waddr_2_s;
  logic [7:0]     wdata_2_s;
  logic           wen_2_s;
  logic [7:0]     addr_3_s;
  logic [7:0]     wdata_3_s;
  logic           wen_3_s;
  logic [7:0]     t_s;
  logic [7:0]     byte_s;
  logic           len_ok_s;

`ifdef RC4_DROP_EN
  localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  logic [DW-1:0]  drop_r;
`else
  // DROP_N only matters when the drop feature is built in.
  logic           unused_drop_s;
  assign unused_drop_s = (DROP_N != 32'sd0);
`endif

  // In GEN_SW2 the S[j] write has not landed yet, so forward si when t hits j.
  assign t_s      = si_r + sj_r;
  assign byte_s   = (t_s == j_r) ? si_r : ram_rdata_1;
  assign len_ok_s = (key_len != {KLW{1'b0}}) && (key_len <= KMAX_L);

  // RAM port drive: read data is same-cycle, so addresses follow the state.
  always_comb begin
    raddr_1_s = 8'd0;
    waddr_2_s = 8'd0;
    wdata_2_s = 8'd0;
    wen_2_s   = 1'b0;
    addr_3_s  = 8'd0;
    wdata_3_s = 8'd0;
    wen_3_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        waddr_2_s = cnt_r;
        wdata_2_s = cnt_r;
        wen_2_s   = 1'b1;
      end
      ST_KSA_RD: begin
        raddr_1_s = i_r;
      end
      ST_GEN_RD: begin
        raddr_1_s = i_r + 8'd1;
      end
      ST_KSA_SW1, ST_GEN_SW1: begin
        addr_3_s  = j_r;
        waddr_2_s = i_r;
        wdata_2_s = ram_rdata_3;
        wen_2_s   = 1'b1;
      end
      ST_KSA_SW2: begin
        addr_3_s  = j_r;
        wdata_3_s = si_r;
        wen_3_s   = 1'b1;
      end
      ST_GEN_SW2: begin
        addr_3_s  = j_r;
        wdata_3_s = si_r;
        wen_3_s   = 1'b1;
        raddr_1_s = t_s;
      end
      default: begin
        raddr_1_s = 8'd0;
      end
    endcase
  end

  // Sequencer: state, indices, key storage and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      i_r          <= 8'd0;
      j_r          <= 8'd0;
      k_r          <= {KLW{1'b0}};
      si_r         <= 8'd0;
      sj_r         <= 8'd0;
      cnt_r        <= 8'd0;
      klen_r       <= {KLW{1'b0}};
      busy_r       <= 1'b0;
      gen_active_r <= 1'b0;
      ks_data_r    <= 8'd0;
      ks_valid_r   <= 1'b0;
      for (int n = 0; n < KEY_MAX; n++) begin
        key_r[n] <= 8'd0;
      end
`ifdef RC4_DROP_EN
      drop_r       <= {DW{1'b0}};
`endif
    end else if (clear) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      gen_active_r <= 1'b0;
      ks_valid_r   <= 1'b0;
      ks_data_r    <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (key_we && (key_addr < KMAX_L)) begin
            key_r[key_addr[KAW-1:0]] <= key_data;
          end
          if (start && len_ok_s) begin
            klen_r  <= key_len;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b1;
            state_r <= ST_INIT;
          end
        end
        ST_INIT: begin
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == 8'd255) begin
            i_r     <= 8'd0;
            j_r     <= 8'd0;
            k_r     <= {KLW{1'b0}};
            state_r <= ST_KSA_RD;
          end
        end
        ST_KSA_RD: begin
          si_r    <= ram_rdata_1;
          j_r     <= j_r + ram_rdata_1 + key_r[k_r[KAW-1:0]];
          k_r     <= (k_r == klen_r - KLW'(1)) ? {KLW{1'b0}} : k_r + KLW'(1);
          state_r <= ST_KSA_SW1;
        end
        ST_KSA_SW1: begin
          sj_r    <= ram_rdata_3;
          state_r <= ST_KSA_SW2;
        end
        ST_KSA_SW2: begin
          if (i_r == 8'd255) begin
            i_r          <= 8'd0;
            j_r          <= 8'd0;
            gen_active_r <= 1'b1;
`ifdef RC4_DROP_EN
            drop_r       <= DW'(DROP_N);
`endif
            state_r      <= ST_GEN_RD;
          end else begin
            i_r     <= i_r + 8'd1;
            state_r <= ST_KSA_RD;
          end
        end
        ST_GEN_RD: begin
          i_r     <= i_r + 8'd1;
          si_r    <= ram_rdata_1;
          j_r     <= j_r + ram_rdata_1;
          state_r <= ST_GEN_SW1;
        end
        ST_GEN_SW1: begin
          sj_r    <= ram_rdata_3;
          state_r <= ST_GEN_SW2;
        end
        ST_GEN_SW2: begin
`ifdef RC4_DROP_EN
          if (drop_r != {DW{1'b0}}) begin
            drop_r  <= drop_r - DW'(1);
            state_r <= ST_GEN_RD;
          end else begin
            ks_data_r  <= byte_s;
            ks_valid_r <= 1'b1;
            state_r    <= ST_GEN_HOLD;
          end
`else
          ks_data_r  <= byte_s;
          ks_valid_r <= 1'b1;
          state_r    <= ST_GEN_HOLD;
`endif
        end
        ST_GEN_HOLD: begin
          if (ks_ready) begin
            ks_valid_r <= 1'b0;
            state_r    <= ST_GEN_RD;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          gen_active_r <= 1'b0;
          ks_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign gen_active  = gen_active_r;
  assign ks_data     = ks_data_r;
  assign ks_valid    = ks_valid_r;
  assign ram_raddr_1 = raddr_1_s;
  assign ram_waddr_2 = waddr_2_s;
  assign ram_wdata_2 = wdata_2_s;
  assign ram_wen_2   = wen_2_s;
  assign ram_addr_3  = addr_3_s;
  assign ram_wdata_3 = wdata_3_s;
  assign ram_wen_3   = wen_3_s;

endmodule

// File: tb/tb_rc4_ctrl.sv
// Directed bench for rc4_ctrl with a behavioural 256x8 S-box RAM.
module tb_rc4_ctrl;

  localparam int KLW = 5;
`ifdef RC4_DROP_EN
  localparam int DROP_OFF = 4;
`else
  localparam int DROP_OFF = 0;
`endif
  localparam int LAT_EXP = 1027 + 3 * DROP_OFF;

  logic           clk;
  logic           rst_n;
  logic           key_we;
  logic [KLW-1:0] key_addr;
  logic [7:0]     key_data;
  logic [KLW-1:0] key_len;
  logic           start;
  logic           clear;
  logic           busy;
  logic           gen_active;
  logic [7:0]     ks_data;
  logic           ks_valid;
  logic           ks_ready;
  logic [7:0]     ram_raddr_1;
  logic [7:0]     ram_rdata_1;
  logic [7:0]     ram_waddr_2;
  logic [7:0]     ram_wdata_2;
  logic           ram_wen_2;
  logic [7:0]     ram_addr_3;
  logic [7:0]     ram_wdata_3;
  logic           ram_wen_3;
  logic [7:0]     ram_rdata_3;

  int vectors;
  int miscompares;
  logic dual_seen;

  logic [7:0] s_mem [256];
  logic [7:0] got [16];
  int         got_cyc [16];
  int         got_n;

  logic [7:0] key_ref  [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                                8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] wiki_ref [6]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};

  rc4_ctrl #(.KEY_MAX(16), .DROP_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr),
    .key_data(key_data), .key_len(key_len), .start(start), .clear(clear),
    .busy(busy), .gen_active(gen_active), .ks_data(ks_data),
    .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ram_raddr_1(ram_raddr_1), .ram_rdata_1(ram_rdata_1),
    .ram_waddr_2(ram_waddr_2), .ram_wdata_2(ram_wdata_2), .ram_wen_2(ram_wen_2),
    .ram_addr_3(ram_addr_3), .ram_wdata_3(ram_wdata_3), .ram_wen_3(ram_wen_3),
    .ram_rdata_3(ram_rdata_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S-box RAM model: combinational reads, writes commit at the edge.
  assign ram_rdata_1 = s_mem[ram_raddr_1];
  assign ram_rdata_3 = s_mem[ram_addr_3];
  always @(posedge clk) begin
    if (ram_wen_2) s_mem[ram_waddr_2] <= ram_wdata_2;
    if (ram_wen_3) s_mem[ram_addr_3] <= ram_wdata_3;
  end

  // Records any cycle in which both write ports are enabled.
  always @(negedge clk) begin
    if (ram_wen_2 && ram_wen_3) dual_seen = 1'b1;
  end

  task automatic load_key(input logic [31:0] bytes, input int n);
    for (int a = 0; a < n; a++) begin
      key_we   = 1'b1;
      key_addr = KLW'(a);
      key_data = bytes[8*a +: 8];
      @(negedge clk);
    end
    key_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [KLW-1:0] len);
    key_len = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_valid(input int base, output int lat);
    int n;
    n = base;
    while (!ks_valid && n < base + 1500) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic collect(input int n);
    int c;
    int cyc;
    c = 0;
    cyc = 0;
    got_n = 0;
    for (int b = 0; b < 16; b++) got[b] = 8'hxx;
    while (got_n < n && c < 2000) begin
      if (ks_valid) begin
        got[got_n]     = ks_data;
        got_cyc[got_n] = cyc;
        got_n++;
      end
      if (got_n < n) begin
        @(negedge clk);
        cyc++;
        c++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (gen_active !== 1'b0) begin
      miscompares++; $display("FAIL reset_gen_active: got %b expected 0", gen_active);
    end
    vectors++;
    if (ks_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_ks_valid: got %b expected 0", ks_valid);
    end
    vectors++;
    if (ks_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_ks_data: got %h expected 00", ks_data);
    end
    vectors++;
    if ({ram_wen_2, ram_wen_3} !== 2'b00) begin
      miscompares++; $display("FAIL reset_wen: got %b expected 00", {ram_wen_2, ram_wen_3});
    end
  endtask

  task automatic test_key_stream();
    int lat;
    ks_ready = 1'b1;
    load_key(32'h0079654B, 3);
    pulse_start(5'd3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL key_busy: got %b expected 1", busy);
    end
    wait_valid(0, lat);
    vectors++;
    if (lat !== LAT_EXP) begin
      miscompares++; $display("FAIL key_latency: got %0d expected %0d", lat, LAT_EXP);
    end
    vectors++;
    if (gen_active !== 1'b1) begin
      miscompares++; $display("FAIL key_gen_active: got %b expected 1", gen_active);
    end
    collect(10 - DROP_OFF);
    for (int b = 0; b < 10 - DROP_OFF; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL key_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    for (int b = 1; b < 4; b++) begin
      vectors++;
      if (got_cyc[b] - got_cyc[b-1] !== 4) begin
        miscompares++;
        $display("FAIL key_rate%0d: got %0d cycles expected 4", b, got_cyc[b] - got_cyc[b-1]);
      end
    end
    do_clear();
  endtask

  task automatic test_wiki_reload();
    int lat;
    load_key(32'h696B6957, 4);
    pulse_start(5'd4);
    wait_valid(0, lat);
    vectors++;
    if (lat !== LAT_EXP) begin
      miscompares++; $display("FAIL wiki_latency: got %0d expected %0d", lat, LAT_EXP);
    end
    collect(6 - DROP_OFF);
    for (int b = 0; b < 6 - DROP_OFF; b++) begin
      vectors++;
      if (got[b] !== wiki_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL wiki_byte%0d: got %h expected %h", b, got[b], wiki_ref[b + DROP_OFF]);
      end
    end
    do_clear();
    load_key(32'h0079654B, 3);
    pulse_start(5'd3);
    wait_valid(0, lat);
    collect(4);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL reload_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    do_clear();
  endtask

  task automatic test_backpressure();
    int lat;
    ks_ready = 1'b0;
    pulse_start(5'd3);
    wait_valid(0, lat);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if ({ks_valid, ks_data} !== {1'b1, key_ref[DROP_OFF]}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid %b data %h expected valid 1 data %h",
                 c, ks_valid, ks_data, key_ref[DROP_OFF]);
      end
      vectors++;
      if ({ram_wen_2, ram_wen_3} !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_nowrite%0d: got %b expected 00", c, {ram_wen_2, ram_wen_3});
      end
      @(negedge clk);
    end
    ks_ready = 1'b1;
    collect(10 - DROP_OFF);
    for (int b = 0; b < 10 - DROP_OFF; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL bp_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    do_clear();
  endtask

  task automatic test_guards();
    int lat;
    pulse_start(5'd0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL guard_len0: got busy %b expected 0", busy);
    end
    pulse_start(5'd17);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL guard_len17: got busy %b expected 0", busy);
    end
    pulse_start(5'd3);
    start    = 1'b1;
    key_len  = 5'd1;
    key_we   = 1'b1;
    key_addr = 5'd0;
    key_data = 8'h00;
    @(negedge clk);
    start  = 1'b0;
    key_we = 1'b0;
    wait_valid(1, lat);
    vectors++;
    if (lat !== LAT_EXP) begin
      miscompares++; $display("FAIL guard_latency: got %0d expected %0d", lat, LAT_EXP);
    end
    collect(4);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL guard_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    do_clear();
  endtask

  task automatic test_abort();
    int lat;
    pulse_start(5'd3);
    repeat (256 + 400) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++;
    if ({busy, gen_active, ks_valid, ram_wen_2, ram_wen_3} !== 5'b00000) begin
      miscompares++;
      $display("FAIL abort_clear: got %b expected 00000",
               {busy, gen_active, ks_valid, ram_wen_2, ram_wen_3});
    end
    pulse_start(5'd3);
    wait_valid(0, lat);
    collect(10 - DROP_OFF);
    for (int b = 0; b < 10 - DROP_OFF; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL abort_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    do_clear();
    ks_ready = 1'b0;
    pulse_start(5'd3);
    wait_valid(0, lat);
    vectors++;
    if (ks_valid !== 1'b1) begin
      miscompares++; $display("FAIL abort_hold: got valid %b expected 1", ks_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, gen_active, ks_valid, ks_data, ram_wen_2, ram_wen_3} !== 13'd0) begin
      miscompares++;
      $display("FAIL abort_rst: got busy %b gen %b valid %b data %h wen %b%b expected all 0",
               busy, gen_active, ks_valid, ks_data, ram_wen_2, ram_wen_3);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ks_ready = 1'b1;
    @(negedge clk);
    load_key(32'h0079654B, 3);
    pulse_start(5'd3);
    wait_valid(0, lat);
    vectors++;
    if (lat !== LAT_EXP) begin
      miscompares++; $display("FAIL rst_latency: got %0d expected %0d", lat, LAT_EXP);
    end
    collect(10 - DROP_OFF);
    for (int b = 0; b < 10 - DROP_OFF; b++) begin
      vectors++;
      if (got[b] !== key_ref[b + DROP_OFF]) begin
        miscompares++;
        $display("FAIL rst_byte%0d: got %h expected %h", b, got[b], key_ref[b + DROP_OFF]);
      end
    end
    do_clear();
  endtask

  task automatic test_no_dual_write();
    vectors++;
    if (dual_seen !== 1'b0) begin
      miscompares++; $display("FAIL dual_write: got %b expected 0", dual_seen);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dual_seen   = 1'b0;
    rst_n       = 1'b0;
    key_we      = 1'b0;
    key_addr    = '0;
    key_data    = 8'h00;
    key_len     = '0;
    start       = 1'b0;
    clear       = 1'b0;
    ks_ready    = 1'b1;
    for (int a = 0; a < 256; a++) s_mem[a] = 8'hA5;
    @(negedge clk);
    test_reset();
    test_key_stream();
    test_wiki_reload();
    test_backpressure();
    test_guards();
    test_abort();
    test_no_dual_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
